fnv1a_hash_engine: RTL and testbench



---
 rtl/fnv1a_hash_engine.sv | 112 +++++++++++
 tb/tb_fnv1a_hash_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fnv1a_hash_engine.sv
// Byte-serial FNV-1a hash engine: folds each accepted byte into a 32-bit hash,
// multiplying by the FNV prime with a 6-cycle shift-add sequence.
module fnv1a_hash_engine #(
    parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic                   busy,
    output logic                   hash_valid,
    output logic [31:0]            hash_out,
    output logic [COUNT_WIDTH-1:0] byte_count,
    input  logic                   rd_next,
    input  logic                   rd_rewind,
    output logic [7:0]             rd_byte
);

    typedef enum logic {IDLE, MUL} state_t;

    state_t                 state, next_state;
    logic [31:0]            hash_q, x_q, acc_q, addend, sum;
    logic [2:0]             step_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [1:0]             ptr_q;
    logic                   hash_valid_q;
    logic                   accept, last_step;

    assign accept    = byte_valid && byte_ready;
    assign last_step = (state == MUL) && (step_q == 3'd5);

    always_ff @(posedge clk) begin
        if (reset || clear) state <= IDLE;
        else                state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = MUL;
            MUL:     if (last_step) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == IDLE) && !clear && !reset;
        busy       = (state == MUL);
    end

    // 16777619 = 2^24 + 2^8 + 2^7 + 2^4 + 2^1 + 2^0, one partial product per step
    always_comb begin
        case (step_q)
            3'd0:    addend = x_q;
            3'd1:    addend = x_q << 1;
            3'd2:    addend = x_q << 4;
            3'd3:    addend = x_q << 7;
            3'd4:    addend = x_q << 8;
            default: addend = x_q << 24;
        endcase
        sum = acc_q + addend;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hash_q       <= OFFSET_BASIS;
            count_q      <= '0;
            hash_valid_q <= 1'b0;
            x_q          <= '0;
            acc_q        <= '0;
            step_q       <= '0;
        end else begin
            hash_valid_q <= 1'b0;
            if (accept) begin
                x_q    <= hash_q ^ {24'd0, byte_in};
                acc_q  <= '0;
                step_q <= '0;
                if (count_q != '1) count_q <= count_q + COUNT_WIDTH'(1);
            end
            if (state == MUL) begin
                acc_q  <= sum;
                step_q <= step_q + 3'd1;
                if (last_step) begin
                    hash_q       <= sum;
                    hash_valid_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear || rd_rewind) ptr_q <= '0;
        else if (rd_next)                ptr_q <= ptr_q + 2'd1;
    end

    always_comb begin
        case (ptr_q)
            2'd0:    rd_byte = hash_q[31:24];
            2'd1:    rd_byte = hash_q[23:16];
            2'd2:    rd_byte = hash_q[15:8];
            default: rd_byte = hash_q[7:0];
        endcase
    end

    assign hash_out   = hash_q;
    assign byte_count = count_q;
    assign hash_valid = hash_valid_q;

endmodule

// File: tb/tb_fnv1a_hash_engine.sv
// Self-checking bench for fnv1a_hash_engine: directed cases plus randomized
// traffic compared against a plain-arithmetic FNV-1a reference model.
module tb_fnv1a_hash_engine;

    localparam int          CW     = 3;
    localparam int          CMAX   = (1 << CW) - 1;
    localparam logic [31:0] OFFSET = 32'h811C9DC5;

    logic          clk = 1'b0;
    logic          reset, clear, byte_valid, rd_next, rd_rewind;
    logic [7:0]    byte_in;
    logic          byte_ready, busy, hash_valid;
    logic [31:0]   hash_out;
    logic [CW-1:0] byte_count;
    logic [7:0]    rd_byte;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hash = OFFSET;
    int          exp_count = 0;
    int          exp_ptr   = 0;
    int unsigned last_wait = 0;

    fnv1a_hash_engine #(.OFFSET_BASIS(OFFSET), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy),
        .hash_valid(hash_valid), .hash_out(hash_out), .byte_count(byte_count),
        .rd_next(rd_next), .rd_rewind(rd_rewind), .rd_byte(rd_byte)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fnv_step(input logic [31:0] h, input logic [7:0] b);
        return (h ^ {24'd0, b}) * 32'd16777619;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        exp_hash  = OFFSET;
        exp_count = 0;
        exp_ptr   = 0;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_hash"}, hash_out, exp_hash);
        check_eq({tag, "_count"}, 32'(byte_count), 32'(exp_count));
    endtask

    // mode 0: drop valid after accept; 1: hold the byte; 2: offer a different byte while busy
    task automatic send(input logic [7:0] b, input int mode);
        logic [31:0] old_h;
        int unsigned waitc;
        waitc      = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        #1;
        while (!byte_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        check_eq("accept_ready", 32'(byte_ready), 32'd1);
        if (!byte_ready) begin
            byte_valid = 1'b0;
            return;
        end
        last_wait = waitc;
        old_h     = exp_hash;
        tick();
        exp_hash = fnv_step(exp_hash, b);
        if (exp_count < CMAX) exp_count++;
        if (mode == 0) byte_valid = 1'b0;
        else if (mode == 2) byte_in = b ^ 8'(($urandom_range(1, 255)));
        for (int i = 0; i < 6; i++) begin
            check_eq("busy_high", 32'(busy), 32'd1);
            check_eq("ready_low", 32'(byte_ready), 32'd0);
            check_eq("hash_hold", hash_out, old_h);
            check_eq("valid_low", 32'(hash_valid), 32'd0);
            tick();
        end
        if (mode == 2) byte_valid = 1'b0;
        check_eq("valid_pulse", 32'(hash_valid), 32'd1);
        check_eq("busy_done", 32'(busy), 32'd0);
        check_state("done");
    endtask

    // accepts a byte then aborts it with clear (or reset) while at MUL step k
    task automatic abort_at(input logic [7:0] b, input int k, input bit use_reset);
        byte_in    = b;
        byte_valid = 1'b1;
        #1;
        check_eq("abort_ready", 32'(byte_ready), 32'd1);
        tick();
        byte_valid = 1'b0;
        repeat (k) tick();
        if (use_reset) reset = 1'b1;
        else           clear = 1'b1;
        #1;
        check_eq("abort_ready_low", 32'(byte_ready), 32'd0);
        tick();
        reset = 1'b0;
        clear = 1'b0;
        model_clear();
        #1;
        check_state("abort");
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_ready_back", 32'(byte_ready), 32'd1);
        for (int i = 0; i < 7; i++) begin
            check_eq("abort_no_pulse", 32'(hash_valid), 32'd0);
            tick();
        end
        check_eq("abort_hash_stays", hash_out, exp_hash);
    endtask

    task automatic clear_with_valid;
        byte_in    = 8'($urandom);
        byte_valid = 1'b1;
        clear      = 1'b1;
        #1;
        check_eq("clr_valid_ready", 32'(byte_ready), 32'd0);
        tick();
        clear      = 1'b0;
        byte_valid = 1'b0;
        model_clear();
        check_state("clr_valid");
        check_eq("clr_valid_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_rd(input string tag);
        logic [31:0] sh;
        sh = exp_hash >> (8 * (3 - exp_ptr));
        check_eq(tag, 32'(rd_byte), 32'(sh[7:0]));
    endtask

    task automatic rd_walk(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            rd_next   = 1'($urandom_range(0, 1));
            rd_rewind = ($urandom_range(0, 3) == 0);
            tick();
            if (rd_rewind)    exp_ptr = 0;
            else if (rd_next) exp_ptr = (exp_ptr + 1) % 4;
            rd_next   = 1'b0;
            rd_rewind = 1'b0;
            check_rd("rd_walk");
        end
    endtask

    initial begin
        logic [7:0] foobar [6];
        foobar = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
        reset = 1'b1; clear = 1'b0; byte_valid = 1'b0; byte_in = '0;
        rd_next = 1'b0; rd_rewind = 1'b0;
        repeat (2) tick();
        check_eq("reset_ready_low", 32'(byte_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_state("reset");
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_valid", 32'(hash_valid), 32'd0);
        check_eq("reset_ready", 32'(byte_ready), 32'd1);

        // readout of the offset basis, MSB first, wrapping after 4 steps
        for (int p = 0; p < 5; p++) begin
            check_rd("rd_basis");
            rd_next = 1'b1;
            tick();
            rd_next = 1'b0;
            exp_ptr = (exp_ptr + 1) % 4;
        end

        send(8'h61, 0);
        check_eq("hash_a", hash_out, 32'hE40C292C);
        tick();
        check_eq("pulse_one_cycle", 32'(hash_valid), 32'd0);

        clear = 1'b1; tick(); clear = 1'b0; model_clear();
        for (int i = 0; i < 6; i++) begin
            send(foobar[i], 1);
            if (i > 0) check_eq("b2b_spacing", last_wait, 32'd0);
        end
        byte_valid = 1'b0;
        check_eq("hash_foobar", hash_out, 32'hBF9CF968);
        check_eq("count_foobar", 32'(byte_count), 32'd6);

        clear = 1'b1; tick(); clear = 1'b0; model_clear();
        send(8'h61, 2);
        check_eq("hash_a_ignored", hash_out, 32'hE40C292C);

        abort_at(8'h61, 3, 1'b0);
        send(8'h61, 0);
        check_eq("hash_a_after_abort", hash_out, 32'hE40C292C);
        abort_at(8'h62, 5, 1'b1);

        clear_with_valid();

        // rewind wins over a simultaneous next
        send(8'h61, 0);
        rd_next = 1'b1; tick(); tick(); rd_next = 1'b0; exp_ptr = (exp_ptr + 2) % 4;
        check_rd("rd_ptr2");
        rd_next = 1'b1; rd_rewind = 1'b1; tick(); rd_next = 1'b0; rd_rewind = 1'b0; exp_ptr = 0;
        check_rd("rd_rewind_wins");
        rd_next = 1'b1; tick(); rd_next = 1'b0; exp_ptr = 1;
        clear = 1'b1; tick(); clear = 1'b0; model_clear();
        check_rd("rd_clear");

        // counter saturates at all-ones
        for (int i = 0; i < CMAX + 2; i++) send(8'($urandom), 0);
        check_eq("count_saturated", 32'(byte_count), 32'(CMAX));

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    send(8'($urandom), int'($urandom_range(0, 2)));
                    byte_valid = 1'b0;
                end
                5:       abort_at(8'($urandom), int'($urandom_range(0, 5)), 1'b0);
                6:       clear_with_valid();
                7:       rd_walk(6);
                8:       repeat ($urandom_range(0, 3)) tick();
                default: begin
                    for (int p = 0; p < 4; p++) begin
                        check_rd("rd_rand");
                        rd_next = 1'b1; tick(); rd_next = 1'b0;
                        exp_ptr = (exp_ptr + 1) % 4;
                    end
                end
            endcase
            check_state("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
